// File: rtl/hf1_pkg.sv
// Shared types and code helpers for the HF1 three-channel counter checker.
package hf1_pkg;

  localparam int unsigned HF1_W = 3;
  localparam int unsigned RUN_W = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  function automatic logic [HF1_W-1:0] gray2bin(input logic [HF1_W-1:0] g);
    logic [HF1_W-1:0] b;
    b[HF1_W-1] = g[HF1_W-1];
    for (int i = int'(HF1_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [HF1_W-1:0] bitrev(input logic [HF1_W-1:0] v);
    logic [HF1_W-1:0] r;
    for (int i = 0; i < int'(HF1_W); i++) begin
      r[i] = v[int'(HF1_W)-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/hf1_code_decode.sv
// Decodes the binary, Gray and bit-reversed channels and flags which ones disagree with binary.
module hf1_code_decode
  import hf1_pkg::*;
(
  input  logic [HF1_W-1:0] ind_i,
  input  logic [HF1_W-1:0] man_i,
  input  logic [HF1_W-1:0] std_i,
  output logic [HF1_W-1:0] vi_o,
  output logic             consistent_o,
  output logic             man_mis_o,
  output logic             std_mis_o
);

  logic [HF1_W-1:0] vm;
  logic [HF1_W-1:0] vs;

  assign vm           = gray2bin(man_i);
  assign vs           = bitrev(std_i);
  assign vi_o         = ind_i;
  assign man_mis_o    = (vm != ind_i);
  assign std_mis_o    = (vs != ind_i);
  assign consistent_o = ~man_mis_o & ~std_mis_o;

endmodule

// File: rtl/hf1_seq_checker.sv
// Sequence checker: locks onto a +1 mod 8 count, flags and counts bad samples while locked,
// and drops lock after MISS_LIM consecutive misses.
module hf1_seq_checker
  import hf1_pkg::*;
#(
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned MISS_LIM = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [HF1_W-1:0] ind_in,
  input  logic [HF1_W-1:0] man_in,
  input  logic [HF1_W-1:0] std_in,
  output logic             locked,
  output logic             err,
  output logic [HF1_W-1:0] mis_mask,
  output logic [HF1_W-1:0] cur_val,
  output logic [CNT_W-1:0] err_cnt
);

  logic [HF1_W-1:0] vi;
  logic             consistent;
  logic             man_mis;
  logic             std_mis;

  hf1_code_decode u_decode (
    .ind_i        (ind_in),
    .man_i        (man_in),
    .std_i        (std_in),
    .vi_o         (vi),
    .consistent_o (consistent),
    .man_mis_o    (man_mis),
    .std_mis_o    (std_mis)
  );

  state_e           state_q,  state_d;
  logic [HF1_W-1:0] exp_q,    exp_d;
  logic [RUN_W-1:0] run_q,    run_d;
  logic [RUN_W-1:0] miss_q,   miss_d;
  logic             locked_q, locked_d;
  logic             err_q,    err_d;
  logic [HF1_W-1:0] mask_q,   mask_d;
  logic [HF1_W-1:0] cur_q,    cur_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             good;

  assign good = consistent && (vi == exp_q);

  // Next-state and output decode; nothing moves on a cycle without valid.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    mask_d  = mask_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    if (valid) begin
      cur_d = vi;
      unique case (state_q)
        SEARCH: begin
          if (consistent) begin
            state_d = ACQUIRE;
            exp_d   = vi + HF1_W'(1);
            run_d   = RUN_W'(1);
          end
        end
        ACQUIRE: begin
          if (!consistent) begin
            state_d = SEARCH;
            run_d   = '0;
          end else if (good) begin
            exp_d = exp_q + HF1_W'(1);
            run_d = run_q + RUN_W'(1);
            if (run_q + RUN_W'(1) == RUN_W'(LOCK_LEN)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            exp_d = vi + HF1_W'(1);
            run_d = RUN_W'(1);
          end
        end
        LOCKED: begin
          // Flywheel: expected value keeps advancing through bad samples.
          exp_d = exp_q + HF1_W'(1);
          if (good) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            mask_d = {(vi != exp_q), std_mis, man_mis};
            miss_d = miss_q + RUN_W'(1);
            if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
            if (miss_q + RUN_W'(1) == RUN_W'(MISS_LIM)) begin
              state_d = SEARCH;
              run_d   = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEARCH;
      exp_q    <= '0;
      run_q    <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      mask_q   <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign mis_mask = mask_q;
  assign cur_val  = cur_q;
  assign err_cnt  = cnt_q;

endmodule
